// File: rtl/candy_mem_ctrl_pkg.sv
// candy_mem_ctrl_pkg
//   Shared definitions for the SRAM-side memory controller: SRAM geometry,
//   read-ready pulse level, FSM state encoding and requester port IDs.
package candy_mem_ctrl_pkg;

  localparam int SRAM_ADDR_W = 16;
  localparam int SRAM_DATA_W = 32;

  // Active level of the SRAM read-ready pulse.
  localparam logic READ_READY = 1'b1;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_RD   = 2'd1,
    MC_WR   = 2'd2,
    MC_RESP = 2'd3
  } mc_state_e;

  // Port IDs double as bit indices into the arbiter req/grant vectors.
  typedef enum logic {
    MC_FETCH = 1'b0,
    MC_DATA  = 1'b1
  } mc_port_e;

  // One-hot grant vector -> port ID (fetch when nothing is granted).
  function automatic mc_port_e grant_port(input logic [1:0] grant);
    return grant[1] ? MC_DATA : MC_FETCH;
  endfunction

endpackage

// File: rtl/candy_mem_arb.sv
// candy_mem_arb
//   Combinational 2-way arbiter with alternating priority.
//   req[0] = fetch, req[1] = data. A lone request always wins; on a tie the
//   port that did not win last time gets the grant.
// Ports:
//   req        in  [1:0]  request vector
//   last_grant in         port granted most recently
//   grant      out [1:0]  one-hot grant (zero when no request)
module candy_mem_arb
  import candy_mem_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  mc_port_e   last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == MC_FETCH) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/candy_mem_ctrl.sv
// candy_mem_ctrl
//   Two-port memory controller in front of the on-chip SRAM. Arbitrates the
//   instruction-fetch port (read only) and the data port (load/store) onto the
//   single SRAM interface, one transaction at a time, waits for the SRAM
//   read-ready pulse and returns the word to the granted port. A read that sees
//   no ready pulse within TIMEOUT cycles completes with data 0 and err=1.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request (held until if_ready)
//   if_ready                 fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata/if_err  fetch response, one-cycle pulse, data/err hold
//   d_req/d_we/d_addr/d_wdata  data request (held until d_ready)
//   d_ready                  data accepted this cycle (combinational)
//   d_rvalid/d_rdata/d_err   load data or store completion pulse
//   sram_we/sram_re          SRAM enables (write needs both high)
//   sram_waddr/sram_wdata    SRAM write address/data
//   sram_raddr               SRAM read address
//   sram_rdata/sram_rdata_ready  SRAM read data and its one-cycle ready pulse
//   busy                     FSM not idle
module candy_mem_ctrl
  import candy_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = SRAM_ADDR_W,
  parameter int DATA_W  = SRAM_DATA_W,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  // SRAM side
  output logic              sram_we,
  output logic              sram_re,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_rdata_ready,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mc_state_e          state;
  mc_port_e           last_grant;
  mc_port_e           lat_port;
  logic [CNT_W-1:0]   cnt;

  logic [1:0]         grant;
  mc_port_e           gport;
  logic               grant_ok;
  logic               rd_hit;
  logic               rd_tmo;
  logic [DATA_W-1:0]  rd_word;

  candy_mem_arb u_arb (
    .req        ({d_req, if_req}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign gport = grant_port(grant);

  // Handshakes only in IDLE; masked under reset so a request seen during the
  // reset cycle is not falsely acknowledged.
  assign grant_ok = (state == MC_IDLE) && !rst;
  assign if_ready = grant_ok && grant[0];
  assign d_ready  = grant_ok && grant[1];
  assign busy     = (state != MC_IDLE);

  // Read completion: a ready pulse in the timeout cycle still wins.
  assign rd_hit  = (sram_rdata_ready == READ_READY);
  assign rd_tmo  = (cnt == CNT_W'(TIMEOUT - 1));
  assign rd_word = rd_hit ? sram_rdata : '0;

  // The sram_* address/data registers are the latched request: they are
  // loaded at grant and held until the next grant of the same kind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MC_IDLE;
      last_grant <= MC_FETCH;
      lat_port   <= MC_FETCH;
      cnt        <= '0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
      sram_we    <= 1'b0;
      sram_re    <= 1'b0;
      sram_waddr <= '0;
      sram_wdata <= '0;
      sram_raddr <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      unique case (state)
        MC_IDLE: begin
          if (grant != 2'b00) begin
            lat_port   <= gport;
            last_grant <= gport;
            if (gport == MC_DATA && d_we) begin
              state      <= MC_WR;
              sram_we    <= 1'b1;
              sram_re    <= 1'b1;
              sram_waddr <= d_addr;
              sram_wdata <= d_wdata;
            end else begin
              state      <= MC_RD;
              sram_re    <= 1'b1;
              sram_raddr <= (gport == MC_DATA) ? d_addr : if_addr;
            end
          end
        end
        MC_RD: begin
          cnt <= cnt + 1'b1;
          if (rd_hit || rd_tmo) begin
            state   <= MC_RESP;
            sram_re <= 1'b0;
            // Response registers load here so the pulse lines up with RESP.
            if (lat_port == MC_DATA) begin
              d_rvalid <= 1'b1;
              d_rdata  <= rd_word;
              d_err    <= !rd_hit;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= rd_word;
              if_err    <= !rd_hit;
            end
          end
        end
        MC_WR: begin
          // Single write cycle; stores always belong to the data port.
          state    <= MC_RESP;
          sram_we  <= 1'b0;
          sram_re  <= 1'b0;
          d_rvalid <= 1'b1;
          d_rdata  <= '0;
          d_err    <= 1'b0;
        end
        MC_RESP: begin
          cnt   <= '0;
          state <= MC_IDLE;
        end
        default: state <= MC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_candy_mem_ctrl.sv
// Testbench for candy_mem_ctrl: table of single transactions plus hand-written
// sequences for arbitration, reset mid-read and stray ready pulses. Expected
// responses are queued at grant time and checked when rvalid appears.
module tb_candy_mem_ctrl;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_ready, if_rvalid, if_err;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req = 1'b0, d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_ready, d_rvalid, d_err;
  logic [DATA_W-1:0] d_rdata;
  logic              sram_we, sram_re, busy;
  logic [ADDR_W-1:0] sram_waddr, sram_raddr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic              sram_rdata_ready;

  candy_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .sram_we(sram_we), .sram_re(sram_re), .sram_waddr(sram_waddr),
    .sram_wdata(sram_wdata), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
    .sram_rdata_ready(sram_rdata_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SRAM model: 1-cycle read latency, one pulse per read
  logic [DATA_W-1:0] mem [0:255];
  logic [255:0]      wvalid;
  logic              mem_clr = 1'b1;
  logic              never_rdy = 1'b0;
  logic              stray = 1'b0;
  logic              model_rdy = 1'b0;

  function automatic logic [DATA_W-1:0] default_word(input logic [ADDR_W-1:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {16'hC0DE, a};
  endfunction

  always @(posedge clk) begin
    if (mem_clr) wvalid <= '0;
    else if (sram_we && sram_re) begin
      mem[sram_waddr[7:0]]    <= sram_wdata;
      wvalid[sram_waddr[7:0]] <= 1'b1;
    end
    model_rdy  <= sram_re && !sram_we && !model_rdy && !never_rdy;
    sram_rdata <= wvalid[sram_raddr[7:0]] ? mem[sram_raddr[7:0]] : default_word(sram_raddr);
  end

  assign sram_rdata_ready = model_rdy | stray;

  // ---------------- checking
  int checks = 0;
  int errors = 0;
  int rvalid_cnt = 0;
  int wr_cnt = 0;
  logic [ADDR_W-1:0] last_waddr = '0;
  logic [DATA_W-1:0] last_wdata = '0;

  typedef struct {
    logic              is_data;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              never;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_err;
    int                exp_lat;
  } vec_t;

  typedef struct {
    logic              port;
    logic [DATA_W-1:0] data;
    logic              err;
    int                due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (sram_we && sram_re) begin
      wr_cnt++;
      last_waddr = sram_waddr;
      last_wdata = sram_wdata;
    end
    if (if_rvalid || d_rvalid) begin
      rvalid_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: if_rvalid=%0b d_rvalid=%0b expected none (cycle %0d)",
                 if_rvalid, d_rvalid, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rvalid_port", {if_rvalid, d_rvalid}, mon_e.port ? 2'b01 : 2'b10);
        chk("rdata", mon_e.port ? d_rdata : if_rdata, mon_e.data);
        chk("err", mon_e.port ? d_err : if_err, mon_e.err);
        chk("rvalid_cycle", cyc, mon_e.due);
      end
    end else if (sb.size() != 0 && cyc > sb[0].due) begin
      checks++;
      errors++;
      $display("FAIL rvalid_missing: none by cycle %0d, required at %0d", cyc, sb[0].due);
      sb.delete(0);
    end
  end

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: busy=%0b pending=%0d expected idle", busy, sb.size());
    end
  endtask

  task automatic do_txn(input vec_t v);
    bit got = 1'b0;
    @(posedge clk); #1;
    never_rdy = v.never;
    if (v.is_data) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (v.is_data ? d_ready : if_ready) begin
        got = 1'b1;
        chk("ready_pair", {if_ready, d_ready}, v.is_data ? 2'b01 : 2'b10);
        sb.push_back('{v.is_data, v.exp_rdata, v.exp_err, cyc + v.exp_lat});
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: no ready for addr 0x%0h", v.addr);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    d_req  = 1'b0;
    drain();
    never_rdy = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    int w0, r0, t;
    bit got;

    //        data we addr      wdata         never exp_rdata     err lat
    vt[0] = '{1'b0, 1'b0, 16'h0010, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 3};
    vt[1] = '{1'b1, 1'b1, 16'h0020, 32'h12345678, 1'b0, 32'h0,        1'b0, 2};
    vt[2] = '{1'b1, 1'b0, 16'h0020, 32'h0,        1'b0, 32'h12345678, 1'b0, 3};
    vt[3] = '{1'b0, 1'b0, 16'h0020, 32'h0,        1'b0, 32'h12345678, 1'b0, 3};
    vt[4] = '{1'b1, 1'b0, 16'h0031, 32'h0,        1'b0, 32'hC0DE0031, 1'b0, 3};
    vt[5] = '{1'b1, 1'b0, 16'h0020, 32'h0,        1'b1, 32'h0,        1'b1, TIMEOUT + 1};
    vt[6] = '{1'b0, 1'b0, 16'h0044, 32'h0,        1'b1, 32'h0,        1'b1, TIMEOUT + 1};
    vt[7] = '{1'b1, 1'b1, 16'h0044, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0, 2};
    vt[8] = '{1'b0, 1'b0, 16'h0044, 32'h0,        1'b0, 32'hCAFEF00D, 1'b0, 3};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {if_ready, if_rvalid, if_err, d_ready, d_rvalid, d_err, sram_we, sram_re, busy}, '0);
    chk("reset_rdata", {if_rdata, d_rdata}, '0);
    chk("reset_sram_addr", {sram_waddr, sram_raddr}, '0);
    chk("reset_sram_wdata", sram_wdata, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_clr = 1'b0;

    // table of single transactions
    for (int i = 0; i < 9; i++) begin
      w0 = wr_cnt;
      do_txn(vt[i]);
      chk("sram_write_cycles", wr_cnt - w0, vt[i].we ? 1 : 0);
      if (vt[i].we) begin
        chk("sram_waddr", last_waddr, vt[i].addr);
        chk("sram_wdata", last_wdata, vt[i].wdata);
      end
    end

    // simultaneous requests after reset: D, F, D, F
    do_reset();
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (if_ready || d_ready) begin
          got = 1'b1;
          chk("alt_grant", {if_ready, d_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
          sb.push_back('{(k % 2 == 0), (k % 2 == 0) ? 32'h12345678 : 32'hDEADBEEF, 1'b0, cyc + 3});
        end
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL alt_grant_timeout: transaction %0d never granted", k);
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    d_req  = 1'b0;
    drain();

    // reset in the first RD cycle drops the load
    r0 = rvalid_cnt;
    w0 = wr_cnt;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    got = 1'b0;
    t = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (d_ready) begin got = 1'b1; t = cyc; end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL rst_rd_grant_timeout: no d_ready");
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rd_cycle", cyc, t + 2);
    chk("rst_rd_busy", busy, 1'b0);
    chk("rst_rd_sram_re", sram_re, 1'b0);
    repeat (6) @(negedge clk);
    chk("rst_rd_no_rvalid", rvalid_cnt - r0, 0);
    chk("rst_rd_no_write", wr_cnt - w0, 0);
    do_txn(vt[2]);

    // stray ready while idle
    r0 = rvalid_cnt;
    @(posedge clk); #1 stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    @(negedge clk);
    chk("stray_busy", busy, 1'b0);
    repeat (4) @(negedge clk);
    chk("stray_no_rvalid", rvalid_cnt - r0, 0);
    do_txn(vt[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
